decoder_4to12: RTL and testbench

Registered binary-to-one-hot decoder for the dual priority encoder datapath. It converts the 4-bit channel code produced by the priority encoder back into a 12-bit one-hot select vector. Codes 0–11 select one line. Codes 12–15 are out of range and select no line.

---
 rtl/decoder_4to12_pkg.sv | 7 +
 rtl/decoder_4to12_core.sv | 19 +
 rtl/decoder_4to12.sv | 49 ++++
 tb/tb_decoder_4to12.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_4to12_pkg.sv
// decoder_4to12_pkg: shared widths and code/one-hot types for the 4-to-12 decoder
package decoder_4to12_pkg;
  localparam int DEC_IN_W = 4;
  localparam int DEC_OUT_W = 12;
  typedef logic [DEC_IN_W-1:0] dec_code_t;
  typedef logic [DEC_OUT_W-1:0] dec_onehot_t;
endpackage

// File: rtl/decoder_4to12_core.sv
// decoder_4to12_core: combinational binary-to-one-hot decode with out-of-range detect
module decoder_4to12_core
  import decoder_4to12_pkg::*;
#(
  parameter int IN_W = DEC_IN_W,
  parameter int OUT_W = DEC_OUT_W
) (
  input  logic [IN_W-1:0]  code,
  output logic [OUT_W-1:0] onehot,
  output logic             out_of_range
);
  localparam logic [IN_W:0] LIM = OUT_W[IN_W:0];
  assign out_of_range = {1'b0, code} >= LIM;
  // per-line equality compare; codes beyond OUT_W-1 match no line, so nothing aliases
  for (genvar k = 0; k < OUT_W; k++) begin : g_line
    localparam logic [IN_W-1:0] K = k[IN_W-1:0];
    assign onehot[k] = code == K;
  end
endmodule

// File: rtl/decoder_4to12.sv
// decoder_4to12: registered 4-bit code to 12-line one-hot decoder; err port with DECODER_4TO12_ERR_EN
module decoder_4to12
  import decoder_4to12_pkg::*;
#(
  parameter int IN_W = DEC_IN_W,
  parameter int OUT_W = DEC_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             out_valid
`ifdef DECODER_4TO12_ERR_EN
  ,
  output logic             err
`endif
);
  if (OUT_W > 2 ** IN_W) begin : g_bad_width
    $error("OUT_W must not exceed 2**IN_W");
  end
  logic [OUT_W-1:0] onehot;
`ifdef DECODER_4TO12_ERR_EN
  logic oor;
`else
  logic unused_oor;
`endif
  decoder_4to12_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .code(in),
    .onehot(onehot),
`ifdef DECODER_4TO12_ERR_EN
    .out_of_range(oor)
`else
    .out_of_range(unused_oor)
`endif
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out <= in_valid ? onehot : out;
    end
  end
`ifdef DECODER_4TO12_ERR_EN
  always_ff @(posedge clk) err <= !rst && in_valid && oor;
`endif
endmodule

// File: tb/tb_decoder_4to12.sv
// tb_decoder_4to12: randomized self-checking bench for decoder_4to12 against an arithmetic model
module tb_decoder_4to12;
  import decoder_4to12_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0;
  dec_code_t in = '0;
  dec_onehot_t out;
  logic out_valid;
`ifdef DECODER_4TO12_ERR_EN
  logic err;
`endif
  int checks = 0, errors = 0;
  dec_onehot_t m_out = '0;
  logic m_v = 0, m_err = 0;

  always #5 clk = ~clk;

  decoder_4to12 dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in(in),
    .out(out),
    .out_valid(out_valid)
`ifdef DECODER_4TO12_ERR_EN
    ,
    .err(err)
`endif
  );

  function automatic dec_onehot_t ref_dec(input int c);
    return c < DEC_OUT_W ? dec_onehot_t'(2 ** c) : '0;
  endfunction

  // advance one clock: model predicts from inputs seen at the edge, outputs checked 1ns later
  task automatic step();
    dec_onehot_t n_out;
    logic n_v, n_err;
    if (rst) begin
      n_out = '0; n_v = 0; n_err = 0;
    end else begin
      n_v = in_valid;
      n_err = in_valid && int'(in) >= DEC_OUT_W;
      n_out = in_valid ? ref_dec(int'(in)) : m_out;
    end
    @(posedge clk);
    #1;
    m_out = n_out; m_v = n_v; m_err = n_err;
    checks++;
    if ($countones(out) > 1) begin
      errors++; $display("FAIL onehot: out=%h, required one-hot or zero", out);
    end
    checks++;
    if (out_valid !== m_v) begin
      errors++; $display("FAIL valid_delay: out_valid=%b, required %b", out_valid, m_v);
    end
    checks++;
    if (out !== m_out) begin
      errors++; $display("FAIL model_out: out=%h, required %h", out, m_out);
    end
`ifdef DECODER_4TO12_ERR_EN
    checks++;
    if (err !== m_err) begin
      errors++; $display("FAIL model_err: err=%b, required %b", err, m_err);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1; in = 5; in_valid = 1;
    repeat (3) begin
      step();
      checks++;
      if (out !== '0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_hold: out=%h valid=%b, required 000/0", out, out_valid);
      end
    end
    rst = 0;
    step();
    checks++;
    if (out !== 12'h020 || out_valid !== 1'b1) begin
      errors++; $display("FAIL reset_release: out=%h valid=%b, required 020/1", out, out_valid);
    end
  endtask

  task automatic test_sweep(input int hold);
    dec_onehot_t one, exp;
    one = 12'h001;
    for (int c = 0; c < 16; c++) begin
      in = dec_code_t'(c); in_valid = 1;
      exp = c < 12 ? one << c : '0;
      repeat (hold) begin
        step();
        checks++;
        if (out !== exp || out_valid !== 1'b1) begin
          errors++; $display("FAIL sweep code %0d: out=%h valid=%b, required %h/1", c, out, out_valid, exp);
        end
`ifdef DECODER_4TO12_ERR_EN
        checks++;
        if (err !== (c >= 12)) begin
          errors++; $display("FAIL sweep_err code %0d: err=%b, required %b", c, err, c >= 12);
        end
`endif
      end
    end
  endtask

  task automatic test_hold();
    in = 3; in_valid = 1;
    step();
    in = 9; in_valid = 0;
    repeat (3) begin
      step();
      checks++;
      if (out !== 12'h008 || out_valid !== 1'b0) begin
        errors++; $display("FAIL hold: out=%h valid=%b, required 008/0", out, out_valid);
      end
    end
  endtask

  task automatic test_boundary();
    in = 11; in_valid = 1;
    step();
    checks++;
    if (out !== 12'h800) begin
      errors++; $display("FAIL boundary_11: out=%h, required 800", out);
    end
`ifdef DECODER_4TO12_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL boundary_err11: err=%b, required 0", err);
    end
`endif
    in = 12;
    step();
    checks++;
    if (out !== 12'h000 || out_valid !== 1'b1) begin
      errors++; $display("FAIL boundary_12: out=%h valid=%b, required 000/1", out, out_valid);
    end
`ifdef DECODER_4TO12_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL boundary_err12: err=%b, required 1", err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    in = 4; in_valid = 1;
    step();
    rst = 1; in = 7;
    step();
    checks++;
    if (out !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid: out=%h valid=%b, required 000/0", out, out_valid);
    end
    rst = 0; in_valid = 0;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst = $urandom_range(0, 19) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      in = dec_code_t'($urandom_range(0, 15));
      step();
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_sweep(1);
    test_sweep(5);
    test_hold();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      in = dec_code_t'($urandom_range(0, 15)); in_valid = 1;
      step();
      checks++;
      if (out !== ref_dec(int'(in)) || out_valid !== 1'b1) begin
        errors++; $display("FAIL back_to_back code %0d: out=%h valid=%b, required %h/1", in, out, out_valid, ref_dec(int'(in)));
      end
    end
  endtask
endmodule
